// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped countdown timer: register offsets,
// CTRL bit layout, mode encodings and FSM state encodings.
package timer_counter_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int EN_BIT   = 0;
  localparam int MODE_LSB = 1;
  localparam int MODE_MSB = 2;
  localparam int IM_BIT   = 3;
  localparam int CTRL_W   = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  // Only 01 auto-reloads; 10 and 11 fall back to one-shot behaviour.
  function automatic logic mode_is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Countdown timer with CTRL/PRESET/COUNT registers; one-shot mode raises a
// sticky interrupt, auto-reload mode emits a one-cycle pulse every P+3 cycles.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] PRESET_INIT = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  irq
);

  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] preset_q, preset_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  irq_flag_q, irq_flag_d;
  state_e                state_q, state_d;

  logic en;
  logic reload;
  logic wr_ctrl;
  logic wr_preset;

  assign en        = ctrl_q[EN_BIT];
  assign reload    = mode_is_reload(ctrl_q[MODE_MSB:MODE_LSB]);
  assign wr_ctrl   = we && (addr == ADDR_CTRL);
  assign wr_preset = we && (addr == ADDR_PRESET);

  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    state_d    = state_q;
    // Bus clear is applied first so that an FSM set on the same edge wins.
    irq_flag_d = (wr_ctrl || wr_preset) ? 1'b0 : irq_flag_q;

    case (state_q)
      IDLE: begin
        if (en) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (count_q != '0) begin
          count_d = count_q - ONE;
        end else begin
          irq_flag_d = 1'b1;
          state_d    = INT;
        end
      end
      INT: begin
        if (reload) begin
          irq_flag_d = 1'b0;
          state_d    = LOAD;
        end else begin
          ctrl_d[EN_BIT] = 1'b0;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus register writes land after the FSM so software always wins on CTRL.
    if (wr_ctrl)   ctrl_d   = din[CTRL_W-1:0];
    if (wr_preset) preset_d = din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= PRESET_INIT;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      state_q    <= IDLE;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      ADDR_CTRL:   dout = {{(DATA_WIDTH-CTRL_W){1'b0}}, ctrl_q};
      ADDR_PRESET: dout = preset_q;
      ADDR_COUNT:  dout = count_q;
      default:     dout = '0;
    endcase
  end

  assign irq = irq_flag_q & ctrl_q[IM_BIT];

endmodule
